// File: rtl/uart_pkg.sv
// uart_pkg: shared TX state encoding and line-level constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_bit_tick.sv
// uart_bit_tick: per-bit prescale counter, pulses bit_end on the last cycle of each bit
module uart_bit_tick #(
  parameter int W = 6
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enable,
  input  logic [W-1:0] prescale,
  input  logic         restart,
  output logic         bit_end
);
  logic [W-1:0] cnt, last;
  always_comb begin
    last = (prescale == '0) ? '0 : prescale - 1'b1;
    bit_end = enable && cnt == last;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt <= '0;
    else cnt <= (restart || !enable || cnt == last) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with prescaler, optional parity,
// one/two stop bits and a one-entry holding buffer for gapless streaming
module uart_tx_param import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
  tx_state_e state;
  logic [DATA_WIDTH-1:0] shifter, hold, load_word;
  logic [PRESCALE_W-1:0] presc_q;
  logic [IW-1:0] bit_idx;
  logic hold_full, par_en_q, par_q, stop2_q, stop_cnt;
  logic accept, bit_end, last_stop, frame_gap, load_hold, load_in, load;
  always_comb begin
    accept = Data_Valid && ready;
    last_stop = state == STOP && bit_end && stop_cnt == stop2_q;
    frame_gap = state == IDLE || last_stop;
    load_hold = frame_gap && hold_full;
    load_in = frame_gap && !hold_full && accept;
    load = load_hold || load_in;
    load_word = hold_full ? hold : P_DATA;
  end
  uart_bit_tick #(.W(PRESCALE_W)) u_tick (
    .CLK(CLK),
    .RST(RST),
    .enable(state != IDLE),
    .prescale(presc_q),
    .restart(load),
    .bit_end(bit_end)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      TX_OUT <= IDLE_LEVEL;
      busy <= 1'b0;
      ready <= 1'b1;
      hold_full <= 1'b0;
      hold <= '0;
      shifter <= '0;
      presc_q <= '0;
      bit_idx <= '0;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      // ready stays low while the buffer is full, so fill and drain never coincide
      if (accept && !load_in) begin
        hold <= P_DATA;
        hold_full <= 1'b1;
        ready <= 1'b0;
      end else if (load_hold) begin
        hold_full <= 1'b0;
        ready <= 1'b1;
      end
      if (load) begin
        shifter <= load_word;
        par_q <= ^load_word ^ (PAR_TYP == PAR_ODD ? 1'b1 : PAR_EVEN);
        par_en_q <= PAR_EN;
        stop2_q <= STOP2;
        presc_q <= PRESCALE;
        bit_idx <= '0;
        stop_cnt <= 1'b0;
        state <= START;
        TX_OUT <= 1'b0;
        busy <= 1'b1;
      end else if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            TX_OUT <= shifter[0];
            shifter <= shifter >> 1;
          end
          DATA: begin
            if (bit_idx == LAST_BIT) begin
              state <= par_en_q ? PARITY : STOP;
              TX_OUT <= par_en_q ? par_q : IDLE_LEVEL;
            end else begin
              TX_OUT <= shifter[0];
              shifter <= shifter >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          PARITY: begin
            state <= STOP;
            TX_OUT <= IDLE_LEVEL;
          end
          STOP: begin
            if (last_stop) begin
              state <= IDLE;
              busy <= 1'b0;
            end else stop_cnt <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param (8-bit and 7-bit instances)
module tb_uart_tx_param;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [5:0] PRESCALE = 6'd1;
  logic ready, TX_OUT, busy;
  logic [6:0] p_data7 = '0;
  logic dv7 = 1'b0;
  logic ready7, tx7, busy7;
  int n_assert = 0, n_fail = 0;
  int wi;
  logic hs;
  logic [31:0] v;
  always #5 CLK = ~CLK;
  uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .ready(ready),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(TX_OUT), .busy(busy)
  );
  uart_tx_param #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data7), .Data_Valid(dv7), .ready(ready7),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(tx7), .busy(busy7)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt, input logic s2, input logic [5:0] ps);
    chk("launch_ready", 32'(ready), 32'd1);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps; Data_Valid = 1'b1;
    step;
    Data_Valid = 1'b0;
  endtask
  task automatic expect_bits(input string tag, input logic [31:0] bits, input int first, input int last, input int p, input logic sel);
    for (int i = first; i <= last; i++)
      for (int k = 0; k < p; k++) begin
        chk($sformatf("%s_tx[%0d.%0d]", tag, i, k), 32'(sel ? tx7 : TX_OUT), 32'(bits[i]));
        chk($sformatf("%s_busy[%0d.%0d]", tag, i, k), 32'(sel ? busy7 : busy), 32'd1);
        step;
      end
  endtask
  task automatic idle_check(input string tag, input logic sel);
    chk({tag, "_idle_tx"}, 32'(sel ? tx7 : TX_OUT), 32'd1);
    chk({tag, "_idle_busy"}, 32'(sel ? busy7 : busy), 32'd0);
  endtask
  initial begin
    @(negedge CLK);
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_tx7", 32'(tx7), 32'd1);
    chk("rst_ready7", 32'(ready7), 32'd1);
    RST = 1'b0;
    step;
    // 0xA5, even parity (four ones -> 0), one stop bit
    launch(8'hA5, 1'b1, 1'b0, 1'b0, 6'd1);
    expect_bits("basic", 32'({1'b1, 1'b0, 8'hA5, 1'b0}), 0, 10, 1, 1'b0);
    idle_check("basic", 1'b0);
    // 0x03, odd parity -> 1, two stop bits; config changes after load must not matter
    launch(8'h03, 1'b1, 1'b1, 1'b1, 6'd4);
    PRESCALE = 6'd7; PAR_TYP = 1'b0; STOP2 = 1'b0; PAR_EN = 1'b0;
    expect_bits("pre4", 32'({3'b111, 8'h03, 1'b0}), 0, 11, 4, 1'b0);
    idle_check("pre4", 1'b0);
    launch(8'h03, 1'b1, 1'b1, 1'b1, 6'd0);
    expect_bits("pre0", 32'({3'b111, 8'h03, 1'b0}), 0, 11, 1, 1'b0);
    idle_check("pre0", 1'b0);
    // back-to-back: 0xF0 buffered two cycles into the 0x55 frame
    v = 32'({1'b1, 8'hF0, 1'b0, 1'b1, 8'h55, 1'b0});
    launch(8'h55, 1'b0, 1'b0, 1'b0, 6'd1);
    expect_bits("b2b", v, 0, 1, 1, 1'b0);
    chk("b2b_ready_pre", 32'(ready), 32'd1);
    P_DATA = 8'hF0; Data_Valid = 1'b1;
    expect_bits("b2b", v, 2, 2, 1, 1'b0);
    Data_Valid = 1'b0;
    P_DATA = 8'h00;
    chk("b2b_ready_full", 32'(ready), 32'd0);
    expect_bits("b2b", v, 3, 9, 1, 1'b0);
    chk("b2b_ready_drained", 32'(ready), 32'd1);
    expect_bits("b2b", v, 10, 19, 1, 1'b0);
    idle_check("b2b", 1'b0);
    // backpressure: Data_Valid held high, word advances only on a handshake
    v = 32'({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
    wi = 0; P_DATA = 8'h11; Data_Valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      hs = ready;
      step;
      if (hs && wi < 3) begin
        wi++;
        if (wi == 3) Data_Valid = 1'b0;
        else P_DATA = (wi == 1) ? 8'h22 : 8'h33;
      end
      chk($sformatf("bp_tx[%0d]", c), 32'(TX_OUT), 32'(v[c]));
    end
    chk("bp_words_taken", 32'(wi), 32'd3);
    step;
    idle_check("bp", 1'b0);
    // reset during data bit 3 of 0x81, then a clean resend
    v = 32'({1'b1, 8'h81, 1'b0});
    launch(8'h81, 1'b0, 1'b0, 1'b0, 6'd1);
    expect_bits("rst1", v, 0, 3, 1, 1'b0);
    RST = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    step;
    RST = 1'b0;
    step;
    idle_check("post_rst", 1'b0);
    launch(8'h81, 1'b0, 1'b0, 1'b0, 6'd1);
    expect_bits("rst2", v, 0, 9, 1, 1'b0);
    idle_check("rst2", 1'b0);
    // 7-bit instance, no parity
    chk("w7_ready", 32'(ready7), 32'd1);
    PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd1; p_data7 = 7'h41; dv7 = 1'b1;
    step;
    dv7 = 1'b0;
    expect_bits("w7", 32'({1'b1, 7'h41, 1'b0}), 0, 8, 1, 1'b1);
    idle_check("w7", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
